timer_counter: RTL and testbench

TIMER_COUNTER -- requirements
Module: timer_counter

---
 rtl/timer_counter_if.sv | 13 +
 rtl/timer_counter.sv | 145 ++++++++++++++
 tb/tb_timer_counter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_counter_if.sv
// Bus bundle between the CPU bridge and the timer: word select, write strobe,
// write data, combinational read data and the registered interrupt request.
interface timer_counter_if;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    // Bridge side drives the access, timer side returns data and interrupt.
    modport master (output addr, we, wdata, input rdata, irq);
    modport slave  (input addr, we, wdata, output rdata, irq);
endinterface

// File: rtl/timer_counter.sv
// Programmable down-counter with one-shot and periodic modes.
// Registers: CTRL (EN, MODE, IM), PRESET, read-only COUNT.
// Handshake: a register write happens on any clk edge where we=1; there is no
// stall, reads are combinational from addr, and irq is a registered level.
module timer_counter #(
    parameter logic [31:0] PRESET_RST = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset,
    timer_counter_if.slave        bus,
    output logic [1:0]            o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_ctrl;
    logic [3:0]  w_ctrl_next;
    logic [31:0] r_preset;
    logic [31:0] w_preset_next;
    logic [31:0] r_count;
    logic [31:0] w_count_next;
    logic        r_irq_flag;
    logic        w_irq_flag_next;
    logic        r_irq;
    logic        w_clear_en;
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_en;
    logic        w_periodic;

    assign w_wr_ctrl   = bus.we && (bus.addr == 2'b00);
    assign w_wr_preset = bus.we && (bus.addr == 2'b01);
    assign w_en        = r_ctrl[0];
    assign w_periodic  = (r_ctrl[2:1] == 2'b01);

    // Next-state, counter and register-file update; the FSM looks at the
    // registered EN, so a CTRL write takes effect on the following edge.
    always_comb begin
        w_state_next    = r_state;
        w_count_next    = r_count;
        w_ctrl_next     = r_ctrl;
        w_preset_next   = r_preset;
        w_irq_flag_next = r_irq_flag;
        w_clear_en      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_en) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_count_next = r_preset;
                w_state_next = S_CNT;
            end
            S_CNT: begin
                if (!w_en) begin
                    w_state_next = S_IDLE;
                end else if (r_count <= 32'd1) begin
                    // Covers PRESET of 0 and 1: expire without wrapping.
                    w_count_next = 32'd0;
                    w_state_next = S_INT;
                end else begin
                    w_count_next = r_count - 32'd1;
                end
            end
            S_INT: begin
                if (w_periodic) begin
                    w_state_next = S_LOAD;
                end else begin
                    w_clear_en   = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Software CTRL write is applied after the hardware EN clear so it wins.
        if (w_clear_en) begin
            w_ctrl_next[0] = 1'b0;
        end
        if (w_wr_ctrl) begin
            w_ctrl_next = bus.wdata[3:0];
        end
        if (w_wr_preset) begin
            w_preset_next = bus.wdata;
        end

        // Flag: cleared by CTRL/PRESET writes, dropped on leaving INT in
        // periodic mode, and set on entry to INT (entry wins so none is lost).
        if (w_wr_ctrl || w_wr_preset) begin
            w_irq_flag_next = 1'b0;
        end
        if ((r_state == S_INT) && w_periodic) begin
            w_irq_flag_next = 1'b0;
        end
        if (w_state_next == S_INT) begin
            w_irq_flag_next = 1'b1;
        end
    end

    // State and register update; irq is registered from next-state values so
    // it rises on the same edge the FSM enters INT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_ctrl     <= 4'd0;
            r_preset   <= PRESET_RST;
            r_count    <= 32'd0;
            r_irq_flag <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ctrl     <= w_ctrl_next;
            r_preset   <= w_preset_next;
            r_count    <= w_count_next;
            r_irq_flag <= w_irq_flag_next;
            r_irq      <= w_ctrl_next[3] & w_irq_flag_next;
        end
    end

    // Combinational read mux; the unused word reads as zero.
    always_comb begin
        bus.rdata = 32'd0;
        case (bus.addr)
            2'b00:   bus.rdata = {28'd0, r_ctrl};
            2'b01:   bus.rdata = r_preset;
            2'b10:   bus.rdata = r_count;
            default: bus.rdata = 32'd0;
        endcase
    end

    assign bus.irq     = r_irq;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: a table of single-edge register
// accesses, then hand-written multi-cycle sequences checked via expected queues.
module tb_timer_counter;

    localparam int W = 32;

    typedef struct {
        logic        rst_n;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [1:0]  rd_addr;
        logic [31:0] exp_rdata;
        logic        exp_irq;
    } vec_t;

    logic          clk;
    logic          reset;
    logic [1:0]    dbg_state;
    logic [W-1:0]  exp_q[$];
    logic          exp_irq_q[$];
    int            n_vec;
    int            n_err;
    vec_t          vecs[14];

    timer_counter_if bus();

    timer_counter #(.PRESET_RST(32'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pop the oldest expected data word and compare.
    task automatic sb_check(input string name, input logic [31:0] act);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got %h with no expected value queued", name, act);
        end else begin
            e = exp_q.pop_front();
            check(name, act, e);
        end
    endtask

    task automatic sb_irq(input string name, input logic act);
        logic e;
        if (exp_irq_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got %b with no expected value queued", name, act);
        end else begin
            e = exp_irq_q.pop_front();
            check(name, {31'd0, act}, {31'd0, e});
        end
    endtask

    task automatic peek(input logic [1:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.rdata;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        bus.we    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        tick();
        bus.we    = 1'b0;
        bus.wdata = 32'd0;
    endtask

    task automatic reset_dut();
        bus.we = 1'b0;
        reset  = 1'b0;
        tick();
        reset  = 1'b1;
    endtask

    // One-shot run: COUNT trajectory and irq are queued when EN is written,
    // then compared each cycle from the second edge after the EN write.
    task automatic run_oneshot(input logic [31:0] p, input logic im,
                               input logic clr_by_preset, input string tag);
        int          m;
        logic [31:0] d;
        m = (p <= 32'd1) ? 1 : int'(p);
        reset_dut();
        do_write(2'b01, p);
        do_write(2'b00, {28'd0, im, 3'b001});
        for (int t = 2; t <= m + 4; t++) begin
            exp_q.push_back((t < 2 + m) ? (p - 32'(t - 2)) : 32'd0);
            exp_irq_q.push_back(im && (t >= 2 + m));
        end
        tick();
        for (int t = 2; t <= m + 4; t++) begin
            tick();
            peek(2'b10, d);
            sb_check($sformatf("%s count t%0d", tag, t), d);
            sb_irq($sformatf("%s irq t%0d", tag, t), bus.irq);
        end
        peek(2'b00, d);
        check({tag, " ctrl en cleared"}, d, {28'd0, im, 3'b000});
        if (clr_by_preset) begin
            do_write(2'b01, p);
        end else begin
            do_write(2'b00, 32'h8);
        end
        check({tag, " irq after clear"}, {31'd0, bus.irq}, 32'd0);
        tick();
        check({tag, " irq stays clear"}, {31'd0, bus.irq}, 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = 2'b00;
        bus.wdata = 32'd0;

        // rst_n, we, addr, wdata, rd_addr, exp_rdata, exp_irq
        vecs[0]  = '{1'b0, 1'b0, 2'd0, 32'h0,        2'd0, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 1'b0, 2'd0, 32'h0,        2'd1, 32'h0,        1'b0};
        vecs[2]  = '{1'b0, 1'b0, 2'd0, 32'h0,        2'd2, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 1'b0, 2'd0, 32'h0,        2'd3, 32'h0,        1'b0};
        vecs[4]  = '{1'b1, 1'b1, 2'd1, 32'hDEADBEEF, 2'd1, 32'hDEADBEEF, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 2'd0, 32'hFFFFFFF0, 2'd0, 32'h0,        1'b0};
        vecs[6]  = '{1'b1, 1'b1, 2'd2, 32'h00001234, 2'd2, 32'h0,        1'b0};
        vecs[7]  = '{1'b1, 1'b1, 2'd3, 32'h00005555, 2'd3, 32'h0,        1'b0};
        vecs[8]  = '{1'b1, 1'b1, 2'd0, 32'h00000006, 2'd0, 32'h6,        1'b0};
        vecs[9]  = '{1'b0, 1'b1, 2'd1, 32'h00000077, 2'd1, 32'h0,        1'b0};
        vecs[10] = '{1'b1, 1'b0, 2'd0, 32'h0,        2'd0, 32'h0,        1'b0};
        vecs[11] = '{1'b1, 1'b1, 2'd1, 32'hA5A5A5A5, 2'd1, 32'hA5A5A5A5, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 2'd0, 32'h00000008, 2'd0, 32'h8,        1'b0};
        vecs[13] = '{1'b1, 1'b0, 2'd0, 32'h0,        2'd2, 32'h0,        1'b0};

        for (int i = 0; i < 14; i++) begin
            reset     = vecs[i].rst_n;
            bus.we    = vecs[i].we;
            bus.addr  = vecs[i].addr;
            bus.wdata = vecs[i].wdata;
            exp_q.push_back(vecs[i].exp_rdata);
            exp_irq_q.push_back(vecs[i].exp_irq);
            tick();
            bus.we = 1'b0;
            reset  = 1'b1;
            peek(vecs[i].rd_addr, d);
            sb_check($sformatf("vec%0d rdata", i), d);
            sb_irq($sformatf("vec%0d irq", i), bus.irq);
        end

        // One-shot, masked one-shot, and the PRESET 0/1 expiry edges.
        run_oneshot(32'd5, 1'b1, 1'b0, "oneshot5");
        run_oneshot(32'd5, 1'b0, 1'b0, "masked5");
        run_oneshot(32'd0, 1'b1, 1'b1, "preset0");
        run_oneshot(32'd1, 1'b1, 1'b0, "preset1");

        // Full-scale preset, PRESET write during CNT, EN=0 freeze, re-enable
        // reload, then reset in mid-count.
        reset_dut();
        do_write(2'b01, 32'hFFFFFFFF);
        do_write(2'b00, 32'h1);
        tick();
        tick();
        peek(2'b10, d); check("big t2", d, 32'hFFFFFFFF);
        tick();
        peek(2'b10, d); check("big t3", d, 32'hFFFFFFFE);
        tick();
        peek(2'b10, d); check("big t4", d, 32'hFFFFFFFD);
        do_write(2'b01, 32'd100);
        peek(2'b10, d); check("preset wr keeps count", d, 32'hFFFFFFFC);
        peek(2'b01, d); check("preset wr readback", d, 32'd100);
        do_write(2'b00, 32'h0);
        peek(2'b10, d); check("en off last step", d, 32'hFFFFFFFB);
        tick();
        tick();
        peek(2'b10, d); check("en off frozen", d, 32'hFFFFFFFB);
        check("en off idle state", {30'd0, dbg_state}, 32'd0);
        do_write(2'b00, 32'h1);
        tick();
        tick();
        peek(2'b10, d); check("reenable reload", d, 32'd100);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int a = 0; a < 4; a++) begin
            peek(2'(a), d);
            check($sformatf("midreset addr%0d", a), d, 32'd0);
        end
        check("midreset irq", {31'd0, bus.irq}, 32'd0);

        // Periodic PRESET=3: one-cycle pulses every PRESET+2 edges
        // (INT, LOAD, then three CNT cycles).
        reset_dut();
        do_write(2'b01, 32'd3);
        do_write(2'b00, 32'hB);
        for (int t = 1; t <= 20; t++) begin
            exp_irq_q.push_back((t >= 5) && ((t - 5) % 5 == 0));
        end
        for (int t = 1; t <= 20; t++) begin
            tick();
            sb_irq($sformatf("periodic irq t%0d", t), bus.irq);
        end
        peek(2'b00, d); check("periodic en kept", d, 32'hB);

        // CTRL write on the same edge as the INT EN clear: software wins.
        reset_dut();
        do_write(2'b01, 32'd2);
        do_write(2'b00, 32'h9);
        for (int t = 1; t <= 4; t++) tick();
        check("collide irq set", {31'd0, bus.irq}, 32'd1);
        do_write(2'b00, 32'h9);
        peek(2'b00, d); check("collide ctrl", d, 32'h9);
        check("collide irq cleared", {31'd0, bus.irq}, 32'd0);
        tick();
        tick();
        peek(2'b10, d); check("collide reload", d, 32'd2);

        if (exp_q.size() != 0 || exp_irq_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL leftover expectations: got %0d/%0d expected 0/0",
                     exp_q.size(), exp_irq_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
